// File: rtl/blast_ddr_rd_sched_if.sv
// ---------------------------------------------------------------------------
// blast_ddr_rd_sched_if
//
// Bundles every non-clock/reset signal of the BLAST DDR read scheduler.
//
// Client side:
//   req_valid   [NCH]         per-client line-read request
//   req_addr    [NCH*ADDR_W]  per-client byte address, client i at [i*ADDR_W +: ADDR_W]
//   req_ready   [NCH]         per-client accept, at most one bit high
//   rsp_valid   [NCH]         one-cycle response pulse to the owning client
//   rsp_data    [DATA_W]      response line shared by all clients
// DDR side:
//   ddr_rd                    read request, held until accepted
//   ddr_rd_addr [ADDR_W]      line-aligned read address
//   ddr_accept                DDR takes the request when ddr_rd && ddr_accept
//   ddr_rd_valid              in-order read response valid
//   ddr_rd_data [DATA_W]      read response line
// Status:
//   outstanding               reads issued but not yet answered
//   err_unexp                 sticky flag: response seen with nothing outstanding
//
// Modports: slave = the scheduler, master = the environment driving it.
// ---------------------------------------------------------------------------
interface blast_ddr_rd_sched_if #(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 32,
    parameter int NCH       = 4,
    parameter int TAG_DEPTH = 8
);
    localparam int OCC_W = $clog2(TAG_DEPTH) + 1;

    logic [NCH-1:0]        req_valid;
    logic [NCH*ADDR_W-1:0] req_addr;
    logic [NCH-1:0]        req_ready;
    logic [NCH-1:0]        rsp_valid;
    logic [DATA_W-1:0]     rsp_data;

    logic                  ddr_rd;
    logic [ADDR_W-1:0]     ddr_rd_addr;
    logic                  ddr_accept;
    logic                  ddr_rd_valid;
    logic [DATA_W-1:0]     ddr_rd_data;

    logic [OCC_W-1:0]      outstanding;
    logic                  err_unexp;

    modport slave (
        input  req_valid, req_addr, ddr_accept, ddr_rd_valid, ddr_rd_data,
        output req_ready, rsp_valid, rsp_data, ddr_rd, ddr_rd_addr,
               outstanding, err_unexp
    );

    modport master (
        output req_valid, req_addr, ddr_accept, ddr_rd_valid, ddr_rd_data,
        input  req_ready, rsp_valid, rsp_data, ddr_rd, ddr_rd_addr,
               outstanding, err_unexp
    );
endinterface

// File: rtl/blast_ddr_rd_sched.sv
// ---------------------------------------------------------------------------
// blast_ddr_rd_sched
//
// DDR read scheduler for the BLAST datapath. Arbitrates line-read requests
// from NCH clients (client 0 = expand fetcher, others = hit-scan stream
// engines) onto the single DDR read port, keeps up to TAG_DEPTH reads in
// flight, and steers each in-order DDR response back to the client that
// issued it.
//
// Parameters:
//   DATA_W     DDR line width in bits (multiple of 8)
//   ADDR_W     byte address width
//   NCH        number of clients, 2..8
//   TAG_DEPTH  maximum outstanding reads, power of two >= 2
//   PRIO_CH0   1: client 0 has strict priority, 0: pure round-robin
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   bus        blast_ddr_rd_sched_if.slave (client, DDR and status signals)
// ---------------------------------------------------------------------------
module blast_ddr_rd_sched #(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 32,
    parameter int NCH       = 4,
    parameter int TAG_DEPTH = 8,
    parameter int PRIO_CH0  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    blast_ddr_rd_sched_if.slave   bus
);

    localparam int IDW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW    = $clog2(TAG_DEPTH);
    localparam int OCC_W = PW + 1;
    localparam int OFF_W = $clog2(DATA_W / 8);

    // Clears the byte-within-line bits so DDR always sees a line address.
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(TAG_DEPTH);

    // -----------------------------------------------------------------------
    // Issue FSM: IDLE may accept a client request, ISSUE holds ddr_rd high
    // until the DDR handshake. Being registered, ddr_rd blocks a new accept
    // in the cycle right after a grant, which caps issue at one per 2 cycles.
    // -----------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } issueState_t;

    issueState_t stateReg, stateNext;

    // Registered state
    logic [IDW-1:0]    rrPtrReg;
    logic [PW-1:0]     headPtrReg;
    logic [PW-1:0]     tailPtrReg;
    logic [OCC_W-1:0]  occReg;
    logic [ADDR_W-1:0] ddrAddrReg;
    logic [NCH-1:0]    rspValidReg;
    logic [DATA_W-1:0] rspDataReg;
    logic              errReg;

    // Order FIFO: client ID of every read still waiting for its response.
    logic [IDW-1:0]    orderMem [TAG_DEPTH];

    // Combinational helpers
    logic [NCH-1:0][ADDR_W-1:0] reqAddrArr;
    logic [NCH-1:0][IDW-1:0]    candIdx;
    logic [NCH-1:0]             candValid;
    logic [NCH-1:0]             headOneHot;
    logic                       grantValid;
    logic [IDW-1:0]             grantIdx;
    logic [IDW-1:0]             rrPtrNext;
    logic [ADDR_W-1:0]          alignedAddr;
    logic                       canAccept;
    logic                       doPush;
    logic                       doPop;
    logic                       unexpRsp;

    // -----------------------------------------------------------------------
    // Per-client slicing and round-robin candidate ordering.
    // candIdx[k] is the client examined k-th in the rotation starting at
    // rrPtrReg; the sum is at most 2*NCH-2, so one conditional subtract
    // performs the modulo even for NCH that is not a power of two.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_client
            logic [IDW:0] candSum;

            assign reqAddrArr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign candSum        = {1'b0, rrPtrReg} + (IDW+1)'(gi);
            assign candIdx[gi]    = (candSum >= (IDW+1)'(NCH))
                                  ? IDW'(candSum - (IDW+1)'(NCH))
                                  : candSum[IDW-1:0];
            assign candValid[gi]  = bus.req_valid[candIdx[gi]];

            assign bus.req_ready[gi] = canAccept && (grantIdx == IDW'(gi));
            assign headOneHot[gi]    = (orderMem[headPtrReg] == IDW'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Grant selection from registered state only (rrPtrReg).
    // -----------------------------------------------------------------------
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        if ((PRIO_CH0 != 0) && bus.req_valid[0]) begin
            grantValid = 1'b1;
            grantIdx   = '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (!grantValid && candValid[k]) begin
                    grantValid = 1'b1;
                    grantIdx   = candIdx[k];
                end
            end
        end
    end

    // Occupancy is the registered count, so a pop in a full cycle does not
    // open a same-cycle accept. Ready is forced low while in reset because
    // registered state is meaningless before the first reset edge.
    assign canAccept = !rst && grantValid && (stateReg == ST_IDLE) && (occReg < OCC_FULL);
    assign doPush    = canAccept;
    assign doPop     = bus.ddr_rd_valid && (occReg != '0);
    assign unexpRsp  = bus.ddr_rd_valid && (occReg == '0);

    // rrPtr moves past the winner even when client 0 won on priority.
    assign rrPtrNext   = (grantIdx == IDW'(NCH - 1)) ? '0 : grantIdx + 1'b1;
    assign alignedAddr = reqAddrArr[grantIdx] & LINE_MASK;

    // -----------------------------------------------------------------------
    // Issue FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= ST_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_IDLE: begin
                if (canAccept) begin
                    stateNext = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.ddr_accept) begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath, FIFO pointers, occupancy and response register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rrPtrReg    <= '0;
            headPtrReg  <= '0;
            tailPtrReg  <= '0;
            occReg      <= '0;
            ddrAddrReg  <= '0;
            rspValidReg <= '0;
            rspDataReg  <= '0;
            errReg      <= 1'b0;
        end else begin
            if (doPush) begin
                ddrAddrReg <= alignedAddr;
                rrPtrReg   <= rrPtrNext;
                tailPtrReg <= tailPtrReg + 1'b1;
            end

            if (doPop) begin
                headPtrReg <= headPtrReg + 1'b1;
                rspDataReg <= bus.ddr_rd_data;
            end

            // Responses cannot be stalled, so rsp_valid is a plain one-cycle pulse.
            rspValidReg <= doPop ? headOneHot : '0;

            case ({doPush, doPop})
                2'b10:   occReg <= occReg + 1'b1;
                2'b01:   occReg <= occReg - 1'b1;
                default: occReg <= occReg;
            endcase

            if (unexpRsp) begin
                errReg <= 1'b1;
            end
        end
    end

    // FIFO storage has no reset; entries are only read behind a valid push.
    always_ff @(posedge clk) begin
        if (doPush) begin
            orderMem[tailPtrReg] <= grantIdx;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.ddr_rd      = (stateReg == ST_ISSUE);
    assign bus.ddr_rd_addr = ddrAddrReg;
    assign bus.rsp_valid   = rspValidReg;
    assign bus.rsp_data    = rspDataReg;
    assign bus.outstanding = occReg;
    assign bus.err_unexp   = errReg;

endmodule
